// File: rtl/ex_div.sv
// ---------------------------------------------------------------------------
// ex_div
//
// Multi-cycle radix-2 restoring divider for the execute stage. It handles
// RV32M DIV, DIVU, REM and REMU. A request is taken in IDLE, and the divider
// then runs one restoring iteration per clock for 32 clocks. After the last
// iteration it loads the sign-corrected quotient or remainder into result_o
// and pulses ready_o for one cycle.
//
// Divide-by-zero and signed overflow (INT_MIN / -1) are resolved on the accept
// edge. They go straight to DONE, so their latency is one cycle.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset; clears every register
//   start_i      in   request strobe, sampled only in IDLE
//   op_i[2:0]    in   funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   dividend_i   in   rs1 value
//   divisor_i    in   rs2 value
//   reg_waddr_i  in   destination register of the instruction
//   flush_i      in   abort any operation in progress; result is unchanged
//   result_o     out  registered quotient/remainder, held until next completion
//   ready_o      out  one-cycle completion pulse (state DONE)
//   busy_o       out  high whenever the divider is not IDLE
//   reg_waddr_o  out  destination register captured at accept
// ---------------------------------------------------------------------------
module ex_div #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    input  logic [4:0]        reg_waddr_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] result_o,
    output logic              ready_o,
    output logic              busy_o,
    output logic [4:0]        reg_waddr_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [DATA_W-1:0] INT_MIN  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] ALL_ONES = {DATA_W{1'b1}};

    state_t            state_q,   state_d;
    logic              rem_sel_q, rem_sel_d;   // 1: return remainder (op_i[1])
    logic              q_neg_q,   q_neg_d;     // quotient must be negated
    logic              r_neg_q,   r_neg_d;     // remainder must be negated
    logic [DATA_W-1:0] dvsr_q,    dvsr_d;      // divisor magnitude
    logic [DATA_W-1:0] dq_q,      dq_d;        // dividend shifting out, quotient shifting in
    logic [DATA_W-1:0] rem_q,     rem_d;       // partial remainder
    logic [4:0]        cnt_q,     cnt_d;       // iteration index 0..31
    logic [DATA_W-1:0] result_q,  result_d;
    logic [4:0]        waddr_q,   waddr_d;

    // Operand magnitudes and signs as seen on the accept edge. Unsigned ops
    // never count as negative, so their operands pass through unchanged.
    logic              a_neg;
    logic              b_neg;
    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;
    logic              accept;
    logic              div_zero;
    logic              sgn_ovf;

    // One restoring iteration. The trial value keeps the bit shifted out of
    // the partial remainder. Without that bit, an unsigned divisor at or
    // above 2^31 would compare against a truncated value.
    logic [DATA_W:0]   trial;
    logic [DATA_W:0]   diff;
    logic              take;
    logic [DATA_W-1:0] rem_step;
    logic [DATA_W-1:0] dq_step;
    logic [DATA_W-1:0] quot_fix;
    logic [DATA_W-1:0] rem_fix;

    // Accept qualification, operand conditioning and the datapath step.
    // This block only computes values; it does not depend on the state.
    always_comb begin
        accept   = start_i && op_i[2] && !flush_i;
        a_neg    = !op_i[0] && dividend_i[DATA_W-1];
        b_neg    = !op_i[0] && divisor_i[DATA_W-1];
        a_mag    = a_neg ? (~dividend_i + 1'b1) : dividend_i;
        b_mag    = b_neg ? (~divisor_i + 1'b1) : divisor_i;
        div_zero = (divisor_i == '0);
        sgn_ovf  = !op_i[0] && (dividend_i == INT_MIN) && (divisor_i == ALL_ONES);

        trial    = {rem_q, dq_q[DATA_W-1]};
        diff     = trial - {1'b0, dvsr_q};
        take     = (trial >= {1'b0, dvsr_q});
        rem_step = take ? diff[DATA_W-1:0] : trial[DATA_W-1:0];
        dq_step  = {dq_q[DATA_W-2:0], take};
        quot_fix = q_neg_q ? (~dq_step + 1'b1) : dq_step;
        rem_fix  = r_neg_q ? (~rem_step + 1'b1) : rem_step;
    end

    // Next-state and next-register logic. Flush is checked first, so it wins
    // over everything else. On flush the visible result and write address are
    // kept exactly as they were.
    always_comb begin
        state_d   = state_q;
        rem_sel_d = rem_sel_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        dvsr_d    = dvsr_q;
        dq_d      = dq_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        waddr_d   = waddr_q;

        if (flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        rem_sel_d = op_i[1];
                        q_neg_d   = a_neg ^ b_neg;
                        r_neg_d   = a_neg;
                        dvsr_d    = b_mag;
                        dq_d      = a_mag;
                        rem_d     = '0;
                        cnt_d     = '0;
                        waddr_d   = reg_waddr_i;
                        // Divide-by-zero returns the raw dividend as the
                        // remainder, not its magnitude.
                        if (div_zero) begin
                            result_d = op_i[1] ? dividend_i : ALL_ONES;
                            state_d  = DONE;
                        end else if (sgn_ovf) begin
                            result_d = op_i[1] ? '0 : INT_MIN;
                            state_d  = DONE;
                        end else begin
                            state_d  = CALC;
                        end
                    end
                end

                CALC: begin
                    rem_d = rem_step;
                    dq_d  = dq_step;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        result_d = rem_sel_q ? rem_fix : quot_fix;
                        state_d  = DONE;
                    end
                end

                DONE: begin
                    state_d = IDLE;
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rem_sel_q <= 1'b0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            dvsr_q    <= '0;
            dq_q      <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            waddr_q   <= '0;
        end else begin
            state_q   <= state_d;
            rem_sel_q <= rem_sel_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            dvsr_q    <= dvsr_d;
            dq_q      <= dq_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            waddr_q   <= waddr_d;
        end
    end

    // All outputs are decoded from registers only.
    always_comb begin
        result_o    = result_q;
        reg_waddr_o = waddr_q;
        ready_o     = (state_q == DONE);
        busy_o      = (state_q != IDLE);
    end

endmodule

// File: tb/tb_ex_div.sv
// ---------------------------------------------------------------------------
// tb_ex_div
//
// Scoreboard bench for ex_div. Each accepted request pushes its expected
// result, write address and latency into a queue. These values come from a
// plain-arithmetic model of the RV32M division rules. A monitor pops one
// entry whenever ready_o is seen and compares it with the outputs.
//
// Ports of the DUT: clk, rst, start_i, op_i, dividend_i, divisor_i,
// reg_waddr_i, flush_i -> result_o, ready_o, busy_o, reg_waddr_o.
// ---------------------------------------------------------------------------
module tb_ex_div;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [2:0]  op_i = 3'b000;
    logic [31:0] dividend_i = '0;
    logic [31:0] divisor_i = '0;
    logic [4:0]  reg_waddr_i = '0;
    logic        flush_i = 1'b0;
    logic [31:0] result_o;
    logic        ready_o;
    logic        busy_o;
    logic [4:0]  reg_waddr_o;

    localparam logic [2:0] OP_DIV  = 3'b100;
    localparam logic [2:0] OP_DIVU = 3'b101;
    localparam logic [2:0] OP_REM  = 3'b110;
    localparam logic [2:0] OP_REMU = 3'b111;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  waddr;
        int          lat;
        longint      acc;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          tests = 0;
    int          fails = 0;
    longint      cyc = 0;
    logic [31:0] last_res = '0;
    longint      acc_tmp;

    ex_div #(.DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .op_i       (op_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .reg_waddr_i(reg_waddr_i),
        .flush_i    (flush_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .busy_o     (busy_o),
        .reg_waddr_o(reg_waddr_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: RV32M semantics written with plain integer arithmetic.
    function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        case (op[1:0])
            2'b00: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            2'b01: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            2'b10: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        if (b == 0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Wait for IDLE, then present one request for a single accept edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] w, output longint acc);
        int n;
        n = 0;
        while (busy_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy_o) begin
            tests++;
            fails++;
            $display("[TB] FAIL issue_wait_idle: busy_o stuck at %0b, expected 0", busy_o);
        end
        @(negedge clk);
        op_i        = op;
        dividend_i  = a;
        divisor_i   = b;
        reg_waddr_i = w;
        start_i     = 1'b1;
        @(posedge clk);
        #1;
        acc     = cyc;
        start_i = 1'b0;
    endtask

    task automatic applyStimulus(input string name, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] w);
        exp_t e;
        longint acc;
        issue(op, a, b, w, acc);
        e.res   = ref_div(op, a, b);
        e.waddr = w;
        e.lat   = ref_lat(op, a, b);
        e.acc   = acc;
        e.name  = name;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy_o) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || busy_o) begin
            tests++;
            fails++;
            $display("[TB] FAIL drain_timeout: pending=%0d busy=%0b, expected 0 and 0",
                     exp_q.size(), busy_o);
        end
    endtask

    // Monitor: each completion pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && ready_o) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_ready: ready_o=1 result=0x%08h, expected no completion",
                         result_o);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput({mon_e.name, "_result"}, result_o, mon_e.res);
                checkOutput({mon_e.name, "_waddr"}, {27'd0, reg_waddr_o}, {27'd0, mon_e.waddr});
                checkOutput({mon_e.name, "_latency"}, 32'(int'(cyc - mon_e.acc) + 1),
                            32'(mon_e.lat));
                checkOutput({mon_e.name, "_busy_in_done"}, {31'd0, busy_o}, 32'd1);
                last_res = mon_e.res;
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          k;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_result", result_o, 32'h0);
        checkOutput("reset_waddr", {27'd0, reg_waddr_o}, 32'h0);
        checkOutput("reset_ready", {31'd0, ready_o}, 32'h0);
        checkOutput("reset_busy", {31'd0, busy_o}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Unsigned basics
        applyStimulus("divu_100_7", OP_DIVU, 32'd100, 32'd7, 5'd11);
        applyStimulus("remu_100_7", OP_REMU, 32'd100, 32'd7, 5'd12);

        // Signed quadrants
        applyStimulus("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd1);
        applyStimulus("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd2);
        applyStimulus("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 5'd3);
        applyStimulus("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 5'd4);

        // Divide by zero
        applyStimulus("divu_by0", OP_DIVU, 32'h1234_5678, 32'd0, 5'd5);
        applyStimulus("div_by0", OP_DIV, 32'h1234_5678, 32'd0, 5'd6);
        applyStimulus("rem_by0", OP_REM, 32'h1234_5678, 32'd0, 5'd7);

        // Overflow
        applyStimulus("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
        applyStimulus("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
        applyStimulus("divu_ovf_operands", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
        applyStimulus("divu_big_divisor", OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 5'd13);
        drain();

        // Flush during CALC iteration 10
        issue(OP_DIVU, 32'd1000, 32'd7, 5'd21, acc_tmp);
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        checkOutput("flush_busy", {31'd0, busy_o}, 32'h0);
        checkOutput("flush_ready", {31'd0, ready_o}, 32'h0);
        checkOutput("flush_result_kept", result_o, last_res);
        repeat (40) @(posedge clk);
        applyStimulus("divu_9_3_after_flush", OP_DIVU, 32'd9, 32'd3, 5'd22);
        drain();

        // start_i with op_i[2]=0 in IDLE is ignored
        @(negedge clk);
        op_i    = 3'b001;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        checkOutput("non_div_start_busy", {31'd0, busy_o}, 32'h0);
        repeat (3) @(posedge clk);

        // start_i pulsed during CALC has no effect
        applyStimulus("divu_50_5_start_in_calc", OP_DIVU, 32'd50, 32'd5, 5'd14);
        repeat (5) @(posedge clk);
        @(negedge clk);
        op_i        = OP_DIV;
        dividend_i  = 32'd99;
        divisor_i   = 32'd1;
        reg_waddr_i = 5'd31;
        start_i     = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        drain();
        repeat (3) @(posedge clk);

        // Reset mid-CALC
        issue(OP_DIVU, 32'd100, 32'd7, 5'd17, acc_tmp);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midcalc_reset_result", result_o, 32'h0);
        checkOutput("midcalc_reset_waddr", {27'd0, reg_waddr_o}, 32'h0);
        checkOutput("midcalc_reset_ready", {31'd0, ready_o}, 32'h0);
        checkOutput("midcalc_reset_busy", {31'd0, busy_o}, 32'h0);
        @(negedge clk);
        rst      = 1'b0;
        last_res = '0;
        applyStimulus("divu_after_reset", OP_DIVU, 32'd100, 32'd7, 5'd18);
        drain();

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            op = {1'b1, 2'($urandom_range(0, 3))};
            k  = $urandom_range(0, 9);
            if (k == 0) begin
                a = $urandom;
                b = 32'd0;
            end else if (k == 1) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end else if (k == 2) begin
                a = 32'($urandom_range(0, 200)) - 32'd100;
                b = 32'($urandom_range(0, 20)) - 32'd10;
            end else begin
                a = $urandom;
                b = $urandom >> $urandom_range(0, 31);
            end
            applyStimulus("random", op, a, b, 5'($urandom_range(0, 31)));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
